// File: rtl/tcdm2axi_bridge.sv
// TCDM slave to AXI4 master bridge: one single-beat 32-bit access in flight at a time,
// placed on the 64-bit AXI data bus in the lane selected by address bit 2.
module tcdm2axi_bridge #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_USER_WIDTH = 6,
    parameter int unsigned AXI_ID_WIDTH   = 6,
    parameter int unsigned AXI_ID         = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        tcdm_slave_req_i,
    input  logic [31:0]                 tcdm_slave_add_i,
    input  logic                        tcdm_slave_type_i,
    input  logic [31:0]                 tcdm_slave_data_i,
    input  logic [3:0]                  tcdm_slave_be_i,
    output logic                        tcdm_slave_gnt_o,
    output logic                        tcdm_slave_r_valid_o,
    output logic [31:0]                 tcdm_slave_r_data_o,
    output logic                        tcdm_slave_r_opc_o,
    output logic                        busy_o,
    output logic                        axi_master_aw_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_master_aw_addr_o,
    output logic [2:0]                  axi_master_aw_prot_o,
    output logic [3:0]                  axi_master_aw_region_o,
    output logic [7:0]                  axi_master_aw_len_o,
    output logic [2:0]                  axi_master_aw_size_o,
    output logic [1:0]                  axi_master_aw_burst_o,
    output logic                        axi_master_aw_lock_o,
    output logic [3:0]                  axi_master_aw_cache_o,
    output logic [3:0]                  axi_master_aw_qos_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_master_aw_id_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_master_aw_user_o,
    input  logic                        axi_master_aw_ready_i,
    output logic                        axi_master_w_valid_o,
    output logic [AXI_DATA_WIDTH-1:0]   axi_master_w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_master_w_strb_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_master_w_user_o,
    output logic                        axi_master_w_last_o,
    input  logic                        axi_master_w_ready_i,
    input  logic                        axi_master_b_valid_i,
    input  logic [1:0]                  axi_master_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_master_b_id_i,
    input  logic [AXI_USER_WIDTH-1:0]   axi_master_b_user_i,
    output logic                        axi_master_b_ready_o,
    output logic                        axi_master_ar_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_master_ar_addr_o,
    output logic [2:0]                  axi_master_ar_prot_o,
    output logic [3:0]                  axi_master_ar_region_o,
    output logic [7:0]                  axi_master_ar_len_o,
    output logic [2:0]                  axi_master_ar_size_o,
    output logic [1:0]                  axi_master_ar_burst_o,
    output logic                        axi_master_ar_lock_o,
    output logic [3:0]                  axi_master_ar_cache_o,
    output logic [3:0]                  axi_master_ar_qos_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_master_ar_id_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_master_ar_user_o,
    input  logic                        axi_master_ar_ready_i,
    input  logic                        axi_master_r_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_master_r_data_i,
    input  logic [1:0]                  axi_master_r_resp_i,
    input  logic                        axi_master_r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_master_r_id_i,
    input  logic [AXI_USER_WIDTH-1:0]   axi_master_r_user_i,
    output logic                        axi_master_r_ready_o
);

    localparam int unsigned TCDM_DW  = 32;
    localparam int unsigned TCDM_BEW = TCDM_DW / 8;
    localparam int unsigned STRB_W   = AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WRITE, B_WAIT, READ, R_WAIT, RESP} state_e;

    state_e               state_q, state_d;
    logic [TCDM_DW-1:0]   add_q, add_d, data_q, data_d, rdata_q, rdata_d;
    logic [TCDM_BEW-1:0]  be_q, be_d;
    logic                 aw_pend_q, aw_pend_d, w_pend_q, w_pend_d, opc_q, opc_d;
    logic                 armed_q;

    // Next state, request latching and per-channel handshake bookkeeping
    always_comb begin
        state_d          = state_q;
        add_d            = add_q;
        data_d           = data_q;
        be_d             = be_q;
        rdata_d          = rdata_q;
        opc_d            = opc_q;
        aw_pend_d        = aw_pend_q;
        w_pend_d         = w_pend_q;
        tcdm_slave_gnt_o = 1'b0;
        case (state_q)
            IDLE: begin
                tcdm_slave_gnt_o = tcdm_slave_req_i & armed_q;
                if (tcdm_slave_req_i && armed_q) begin
                    add_d  = tcdm_slave_add_i;
                    data_d = tcdm_slave_data_i;
                    be_d   = tcdm_slave_be_i;
                    if (tcdm_slave_type_i) begin
                        state_d = READ;
                    end else begin
                        state_d   = WRITE;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end
                end
            end
            WRITE: begin
                aw_pend_d = aw_pend_q & ~axi_master_aw_ready_i;
                w_pend_d  = w_pend_q & ~axi_master_w_ready_i;
                if (!aw_pend_d && !w_pend_d) state_d = B_WAIT;
            end
            B_WAIT: begin
                if (axi_master_b_valid_i) begin
                    rdata_d = '0;
                    opc_d   = axi_master_b_resp_i[1];
                    state_d = RESP;
                end
            end
            READ: begin
                if (axi_master_ar_ready_i) state_d = R_WAIT;
            end
            R_WAIT: begin
                if (axi_master_r_valid_i) begin
                    rdata_d = add_q[2] ? axi_master_r_data_i[2*TCDM_DW-1:TCDM_DW]
                                       : axi_master_r_data_i[TCDM_DW-1:0];
                    opc_d   = axi_master_r_resp_i[1];
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // armed_q keeps the grant low while reset is asserted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            add_q     <= '0;
            data_q    <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            opc_q     <= 1'b0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            add_q     <= add_d;
            data_q    <= data_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            opc_q     <= opc_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            armed_q   <= 1'b1;
        end
    end

    assign busy_o               = (state_q != IDLE);
    assign tcdm_slave_r_valid_o = (state_q == RESP);
    assign tcdm_slave_r_data_o  = rdata_q;
    assign tcdm_slave_r_opc_o   = opc_q;

    assign axi_master_aw_valid_o  = aw_pend_q;
    assign axi_master_aw_addr_o   = AXI_ADDR_WIDTH'(add_q);
    assign axi_master_aw_prot_o   = 3'd0;
    assign axi_master_aw_region_o = 4'd0;
    assign axi_master_aw_len_o    = 8'd0;
    assign axi_master_aw_size_o   = 3'd2;
    assign axi_master_aw_burst_o  = 2'b01;
    assign axi_master_aw_lock_o   = 1'b0;
    assign axi_master_aw_cache_o  = 4'd0;
    assign axi_master_aw_qos_o    = 4'd0;
    assign axi_master_aw_id_o     = AXI_ID_WIDTH'(AXI_ID);
    assign axi_master_aw_user_o   = '0;

    assign axi_master_w_valid_o = w_pend_q;
    assign axi_master_w_data_o  = AXI_DATA_WIDTH'({data_q, data_q});
    assign axi_master_w_strb_o  = add_q[2] ? STRB_W'({be_q, {TCDM_BEW{1'b0}}}) : STRB_W'(be_q);
    assign axi_master_w_user_o  = '0;
    assign axi_master_w_last_o  = 1'b1;
    assign axi_master_b_ready_o = (state_q == B_WAIT);

    assign axi_master_ar_valid_o  = (state_q == READ);
    assign axi_master_ar_addr_o   = AXI_ADDR_WIDTH'(add_q);
    assign axi_master_ar_prot_o   = 3'd0;
    assign axi_master_ar_region_o = 4'd0;
    assign axi_master_ar_len_o    = 8'd0;
    assign axi_master_ar_size_o   = 3'd2;
    assign axi_master_ar_burst_o  = 2'b01;
    assign axi_master_ar_lock_o   = 1'b0;
    assign axi_master_ar_cache_o  = 4'd0;
    assign axi_master_ar_qos_o    = 4'd0;
    assign axi_master_ar_id_o     = AXI_ID_WIDTH'(AXI_ID);
    assign axi_master_ar_user_o   = '0;
    assign axi_master_r_ready_o   = (state_q == R_WAIT);

    // Response ids/users and the low resp bit carry nothing the TCDM side can use
    logic unused_inputs;
    assign unused_inputs = ^{axi_master_b_resp_i[0], axi_master_b_id_i, axi_master_b_user_i,
                             axi_master_r_resp_i[0], axi_master_r_last_i, axi_master_r_id_i,
                             axi_master_r_user_i};

endmodule

// File: tb/tb_tcdm2axi_bridge.sv
// Bench for tcdm2axi_bridge: acts as TCDM master and AXI slave; directed vector table,
// hand-written reset sequence and randomized transactions against a behavioural model.
module tb_tcdm2axi_bridge;

    localparam int unsigned BRIDGE_ID = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req = 1'b0, typ = 1'b0;
    logic [31:0] add = '0, wdat = '0;
    logic [3:0]  be = '0;
    logic        t_gnt, t_rvalid, t_opc, busy;
    logic [31:0] t_rdata;

    logic        aw_valid, aw_lock, aw_ready = 1'b0;
    logic [63:0] aw_addr;
    logic [2:0]  aw_prot, aw_size;
    logic [3:0]  aw_region, aw_cache, aw_qos;
    logic [7:0]  aw_len;
    logic [1:0]  aw_burst;
    logic [5:0]  aw_id, aw_user;
    logic        w_valid, w_last, w_ready = 1'b0;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic [5:0]  w_user;
    logic        b_valid = 1'b0, b_ready;
    logic [1:0]  b_resp = '0;
    logic [5:0]  b_id = '0, b_user = '0;
    logic        ar_valid, ar_lock, ar_ready = 1'b0;
    logic [63:0] ar_addr;
    logic [2:0]  ar_prot, ar_size;
    logic [3:0]  ar_region, ar_cache, ar_qos;
    logic [7:0]  ar_len;
    logic [1:0]  ar_burst;
    logic [5:0]  ar_id, ar_user;
    logic        r_valid = 1'b0, r_last = 1'b0, r_ready;
    logic [63:0] r_data = '0;
    logic [1:0]  r_resp = '0;
    logic [5:0]  r_id = '0, r_user = '0;

    tcdm2axi_bridge #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_USER_WIDTH(6),
                      .AXI_ID_WIDTH(6), .AXI_ID(BRIDGE_ID)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .tcdm_slave_req_i(req), .tcdm_slave_add_i(add), .tcdm_slave_type_i(typ),
        .tcdm_slave_data_i(wdat), .tcdm_slave_be_i(be), .tcdm_slave_gnt_o(t_gnt),
        .tcdm_slave_r_valid_o(t_rvalid), .tcdm_slave_r_data_o(t_rdata),
        .tcdm_slave_r_opc_o(t_opc), .busy_o(busy),
        .axi_master_aw_valid_o(aw_valid), .axi_master_aw_addr_o(aw_addr),
        .axi_master_aw_prot_o(aw_prot), .axi_master_aw_region_o(aw_region),
        .axi_master_aw_len_o(aw_len), .axi_master_aw_size_o(aw_size),
        .axi_master_aw_burst_o(aw_burst), .axi_master_aw_lock_o(aw_lock),
        .axi_master_aw_cache_o(aw_cache), .axi_master_aw_qos_o(aw_qos),
        .axi_master_aw_id_o(aw_id), .axi_master_aw_user_o(aw_user),
        .axi_master_aw_ready_i(aw_ready),
        .axi_master_w_valid_o(w_valid), .axi_master_w_data_o(w_data),
        .axi_master_w_strb_o(w_strb), .axi_master_w_user_o(w_user),
        .axi_master_w_last_o(w_last), .axi_master_w_ready_i(w_ready),
        .axi_master_b_valid_i(b_valid), .axi_master_b_resp_i(b_resp),
        .axi_master_b_id_i(b_id), .axi_master_b_user_i(b_user),
        .axi_master_b_ready_o(b_ready),
        .axi_master_ar_valid_o(ar_valid), .axi_master_ar_addr_o(ar_addr),
        .axi_master_ar_prot_o(ar_prot), .axi_master_ar_region_o(ar_region),
        .axi_master_ar_len_o(ar_len), .axi_master_ar_size_o(ar_size),
        .axi_master_ar_burst_o(ar_burst), .axi_master_ar_lock_o(ar_lock),
        .axi_master_ar_cache_o(ar_cache), .axi_master_ar_qos_o(ar_qos),
        .axi_master_ar_id_o(ar_id), .axi_master_ar_user_o(ar_user),
        .axi_master_ar_ready_i(ar_ready),
        .axi_master_r_valid_i(r_valid), .axi_master_r_data_i(r_data),
        .axi_master_r_resp_i(r_resp), .axi_master_r_last_i(r_last),
        .axi_master_r_id_i(r_id), .axi_master_r_user_i(r_user),
        .axi_master_r_ready_o(r_ready)
    );

    typedef struct {
        logic        is_read;
        logic [31:0] add;
        logic [31:0] data;
        logic [3:0]  be;
        int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
        logic [1:0]  resp;
        logic [63:0] axi_rdata;
        logic        hold_req;
        logic [31:0] exp_rdata;
        logic        exp_opc;
        logic [7:0]  exp_strb;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    // Expected TCDM-side results from the address/lane rules, in plain arithmetic
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int   lane = v.add[2] ? 1 : 0;
        r.exp_strb  = 8'(32'(v.be) << (4 * lane));
        r.exp_rdata = v.is_read ? 32'(v.axi_rdata >> (32 * lane)) : 32'h0;
        r.exp_opc   = (v.resp >= 2'd2);
        return r;
    endfunction

    function automatic vec_t mk(input logic rd, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] b, input int awd, input int wd, input int ard,
                                input int bd, input int rdl, input logic [1:0] rs,
                                input logic [63:0] rdat, input logic hold);
        vec_t v;
        v.is_read = rd; v.add = a; v.data = d; v.be = b;
        v.aw_dly = awd; v.w_dly = wd; v.ar_dly = ard; v.b_dly = bd; v.r_dly = rdl;
        v.resp = rs; v.axi_rdata = rdat; v.hold_req = hold;
        v.exp_rdata = '0; v.exp_opc = 1'b0; v.exp_strb = '0;
        return v;
    endfunction

    localparam logic [40:0] EXP_FIELDS = {8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0,
                                          6'(BRIDGE_ID), 6'd0};

    // One complete TCDM transaction, with the bench as a delay-programmable AXI slave
    task automatic run(input vec_t v);
        int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0;
        bit aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0, done = 0;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_rvalid", 64'(t_rvalid), 64'(0));
        req = 1'b1; add = v.add; typ = v.is_read; wdat = v.data; be = v.be;
        #1;
        check("gnt", 64'(t_gnt), 64'(1));
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            check("busy", 64'(busy), 64'(1));
            if (v.hold_req) check("gnt_while_busy", 64'(t_gnt), 64'(0));
            req = v.hold_req; add = $urandom; typ = 1'($urandom); wdat = $urandom;
            be = 4'($urandom);
            if (cyc == 1 && !v.is_read) check("aw_w_valid_c1", 64'({aw_valid, w_valid}), 64'(3));
            if (cyc == 1 && v.is_read) check("ar_valid_c1", 64'(ar_valid), 64'(1));
            if (v.is_read) check("no_write_chan", 64'({aw_valid, w_valid}), 64'(0));
            else check("no_ar", 64'(ar_valid), 64'(0));
            if (aw_valid) begin
                check("aw_after_hs", 64'(aw_hs), 64'(0));
                check("aw_addr", aw_addr, 64'(v.add));
                check("aw_fields", 64'({aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
                                        aw_region, aw_qos, aw_id, aw_user}), 64'(EXP_FIELDS));
                aw_n++;
            end
            if (w_valid) begin
                check("w_after_hs", 64'(w_hs), 64'(0));
                check("w_data", w_data, 64'(v.data) * 64'h1_0000_0001);
                check("w_beat", 64'({w_last, w_user, w_strb}), 64'({1'b1, 6'd0, v.exp_strb}));
                w_n++;
            end
            if (ar_valid) begin
                check("ar_after_hs", 64'(ar_hs), 64'(0));
                check("ar_addr", ar_addr, 64'(v.add));
                check("ar_fields", 64'({ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
                                        ar_region, ar_qos, ar_id, ar_user}), 64'(EXP_FIELDS));
                ar_n++;
            end
            if (b_ready) check("b_ready_window", 64'(aw_hs && w_hs && !b_hs), 64'(1));
            if (r_ready) check("r_ready_window", 64'(ar_hs && !r_hs), 64'(1));
            if (t_rvalid) begin
                check("rvalid_after_resp", 64'(b_hs || r_hs), 64'(1));
                check("r_data", 64'(t_rdata), 64'(v.exp_rdata));
                check("r_opc", 64'(t_opc), 64'(v.exp_opc));
                done = 1;
            end
            // B and R responses use handshake flags from earlier cycles only
            if (!b_hs && aw_hs && w_hs) begin
                b_valid = (b_n >= v.b_dly);
                b_n++;
                b_resp = b_valid ? v.resp : 2'($urandom);
                if (b_valid && b_ready) b_hs = 1;
            end else begin
                b_valid = 1'b0;
            end
            if (!r_hs && ar_hs) begin
                r_valid = (r_n >= v.r_dly);
                r_n++;
                r_data = r_valid ? v.axi_rdata : {$urandom, $urandom};
                r_resp = r_valid ? v.resp : 2'($urandom);
                r_last = 1'($urandom);
                if (r_valid && r_ready) r_hs = 1;
            end else begin
                r_valid = 1'b0;
            end
            aw_ready = aw_valid ? (aw_n > v.aw_dly) : 1'($urandom);
            w_ready  = w_valid ? (w_n > v.w_dly) : 1'($urandom);
            ar_ready = ar_valid ? (ar_n > v.ar_dly) : 1'($urandom);
            if (aw_valid && aw_ready) aw_hs = 1;
            if (w_valid && w_ready) w_hs = 1;
            if (ar_valid && ar_ready) ar_hs = 1;
        end
        check("completed", 64'(done), 64'(1));
        if (v.is_read) begin
            check("ar_valid_cycles", 64'(ar_n), 64'(v.ar_dly + 1));
        end else begin
            check("aw_valid_cycles", 64'(aw_n), 64'(v.aw_dly + 1));
            check("w_valid_cycles", 64'(w_n), 64'(v.w_dly + 1));
        end
    endtask

    vec_t dir[7];

    initial begin
        // is_read, add, data, be, aw/w/ar/b/r delays, resp, AXI read data, hold req
        dir[0] = mk(0, 32'h104, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'd0, 64'h0, 0);
        dir[0].exp_rdata = 32'h0; dir[0].exp_opc = 0; dir[0].exp_strb = 8'hF0;
        dir[1] = mk(1, 32'h100, 32'h0, 4'hF, 0, 0, 3, 0, 1, 2'd0, 64'h11112222_33334444, 0);
        dir[1].exp_rdata = 32'h33334444; dir[1].exp_opc = 0; dir[1].exp_strb = 8'h0F;
        dir[2] = mk(0, 32'h208, 32'h12345678, 4'h5, 1, 4, 0, 1, 0, 2'd0, 64'h0, 0);
        dir[2].exp_rdata = 32'h0; dir[2].exp_opc = 0; dir[2].exp_strb = 8'h05;
        dir[3] = mk(1, 32'h10C, 32'h0, 4'hF, 0, 0, 0, 0, 2, 2'd2, 64'hAAAA5555_0F0F1234, 0);
        dir[3].exp_rdata = 32'hAAAA5555; dir[3].exp_opc = 1; dir[3].exp_strb = 8'hF0;
        dir[4] = mk(0, 32'h0, 32'h0BADF00D, 4'h3, 0, 0, 0, 0, 0, 2'd3, 64'h0, 0);
        dir[4].exp_rdata = 32'h0; dir[4].exp_opc = 1; dir[4].exp_strb = 8'h03;
        dir[5] = mk(1, 32'h204, 32'h0, 4'hF, 0, 0, 1, 0, 2, 2'd0, 64'hCAFEF00D_01234567, 1);
        dir[5].exp_rdata = 32'hCAFEF00D; dir[5].exp_opc = 0; dir[5].exp_strb = 8'hF0;
        dir[6] = mk(0, 32'h300, 32'h55AA55AA, 4'hC, 2, 0, 0, 2, 0, 2'd1, 64'h0, 0);
        dir[6].exp_rdata = 32'h0; dir[6].exp_opc = 0; dir[6].exp_strb = 8'h0C;

        req = 1'b1;
        #3;
        check("rst_outputs", 64'({t_gnt, t_rvalid, t_opc, busy, aw_valid, w_valid, b_ready,
                                   ar_valid, r_ready}), 64'(0));
        check("rst_rdata", 64'(t_rdata), 64'(0));
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run(dir[i]);
        req = 1'b0;

        // Reset while waiting for B: everything drops at once, a late B is ignored
        run(dir[3]);
        @(negedge clk);
        req = 1'b1; add = 32'h40; typ = 1'b0; wdat = 32'h1; be = 4'hF;
        aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b0;
        @(negedge clk);
        req = 1'b0;
        check("rst_seq_aw_w", 64'({aw_valid, w_valid}), 64'(3));
        @(negedge clk);
        check("rst_seq_b_wait", 64'({b_ready, busy}), 64'(3));
        req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", 64'({t_gnt, t_rvalid, t_opc, busy, aw_valid, w_valid,
                                         b_ready, ar_valid, r_ready}), 64'(0));
        check("async_rst_rdata", 64'(t_rdata), 64'(0));
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; b_valid = 1'b1; b_resp = 2'd2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("late_b_ignored", 64'({t_rvalid, busy, b_ready}), 64'(0));
        end
        b_valid = 1'b0;
        aw_ready = 1'b0; w_ready = 1'b0;
        run(dir[0]);

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v = mk(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 2'($urandom), {$urandom, $urandom}, 1'b0);
            v = model(v);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
